// File: rtl/filter_test_sequencer.sv
// Drives a stimulus ROM into a filter and captures the filter output into a RAM.
// A valid shift register and an address delay line line each address up with its filter result.
module filter_test_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int ROM_LAT  = 1,
  parameter int FILT_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_samples,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              filt_en,
  output logic [DATA_W-1:0] filt_in,
  input  logic [DATA_W-1:0] filt_out,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic              trig
);

  localparam int L   = ROM_LAT + FILT_LAT;
  localparam int DCW = $clog2(L + 1);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [DCW-1:0]  DRAIN_END = DCW'(L - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   cnt_reg;
  logic [ADDR_W:0]   n_reg;
  logic [DCW-1:0]    dcnt_reg;
  logic [L-1:0]      vld_reg;
  logic [ADDR_W-1:0] adr_reg [L];
  logic              last_addr;
  logic              drain_end;
  logic              issue;

  // The count is one bit wider than the address so that N = 2^ADDR_W still terminates.
  assign last_addr = ((cnt_reg + CNT_ONE) == n_reg);
  assign drain_end = (dcnt_reg == DRAIN_END);
  assign issue     = (state_reg == READ);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = READ;
      READ:    if (last_addr) state_next = DRAIN;
      DRAIN:   if (drain_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      n_reg     <= '0;
      dcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          dcnt_reg <= '0;
          if (start) begin
            cnt_reg <= '0;
            n_reg   <= {1'b0, num_samples} + CNT_ONE;
          end
        end
        READ: begin
          dcnt_reg <= '0;
          if (!last_addr) cnt_reg <= cnt_reg + CNT_ONE;
        end
        DRAIN:   dcnt_reg <= dcnt_reg + DCW'(1);
        default: dcnt_reg <= '0;
      endcase
    end
  end

  // Stage i holds the issue flag and address from i+1 cycles ago.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_reg <= '0;
      for (int i = 0; i < L; i++) adr_reg[i] <= '0;
    end else begin
      vld_reg    <= {vld_reg[L-2:0], issue};
      adr_reg[0] <= rom_addr;
      for (int i = 1; i < L; i++) adr_reg[i] <= adr_reg[i-1];
    end
  end

  assign rom_addr = cnt_reg[ADDR_W-1:0];
  assign filt_en  = vld_reg[ROM_LAT-1];
  assign filt_in  = filt_en ? rom_data : '0;
  assign ram_wren = vld_reg[L-1];
  assign ram_addr = adr_reg[L-1];
  assign ram_data = ram_wren ? filt_out : '0;
  assign busy     = (state_reg == READ) || (state_reg == DRAIN);
  assign done     = (state_reg == DONE);
  assign trig     = issue && (cnt_reg == '0);

endmodule

// File: tb/tb_filter_test_sequencer.sv
// Directed bench for filter_test_sequencer: a default-latency instance and a
// ROM_LAT=2 / FILT_LAT=7 instance share stimulus.
module tb_filter_test_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_samples;
  logic [31:0] rom_data;
  logic [31:0] filt_out;
  int          cyc = 0;

  logic [7:0]  rom_addr, ram_addr;
  logic [31:0] filt_in, ram_data;
  logic        filt_en, ram_wren, busy, done, trig;

  logic [7:0]  rom_addr2, ram_addr2;
  logic [31:0] filt_in2, ram_data2;
  logic        filt_en2, ram_wren2, busy2, done2, trig2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rom_data <= {24'hA5A5A5, rom_addr};
  end
  assign filt_out = 32'h5A00_0000 + cyc;

  filter_test_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .rom_addr(rom_addr), .rom_data(rom_data), .filt_en(filt_en), .filt_in(filt_in),
    .filt_out(filt_out), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .busy(busy), .done(done), .trig(trig)
  );

  filter_test_sequencer #(.ROM_LAT(2), .FILT_LAT(7)) dut2 (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .rom_addr(rom_addr2), .rom_data(rom_data), .filt_en(filt_en2), .filt_in(filt_in2),
    .filt_out(filt_out), .ram_addr(ram_addr2), .ram_data(ram_data2), .ram_wren(ram_wren2),
    .busy(busy2), .done(done2), .trig(trig2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] n);
    num_samples = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    logic [127:0] obs;
    rst = 1'b0; start = 1'b0; num_samples = 8'd0;
    tick(); tick();
    obs = {rom_addr, ram_addr, ram_data, filt_in, filt_en, ram_wren, busy, done, trig,
           rom_addr2, ram_addr2, ram_wren2, filt_en2, busy2, done2, trig2, 16'h0};
    n_cmp++;
    if (obs !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_state got=%h exp=0", obs);
    end
    rst = 1'b1;
    tick();
    $display("reset: outputs checked while rst low");
  endtask

  task automatic test_basic;
    logic [4:0] o, e;
    logic [7:0] ea;
    launch(8'd3);
    for (int c = 1; c <= 12; c++) begin
      e  = {c <= 9, c == 10, c == 1, c >= 2 && c <= 5, c >= 6 && c <= 9};
      o  = {busy, done, trig, filt_en, ram_wren};
      ea = (c <= 4) ? 8'(c - 1) : 8'd3;
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL basic_ctrl c=%0d got=%b exp=%b (busy,done,trig,en,wren)", c, o, e);
      end
      n_cmp++;
      if (rom_addr !== ea) begin
        n_bad++;
        $display("FAIL basic_rom_addr c=%0d got=%0d exp=%0d", c, rom_addr, ea);
      end
      if (c >= 2 && c <= 5) begin
        n_cmp++;
        if (filt_in !== {24'hA5A5A5, 8'(c - 2)}) begin
          n_bad++;
          $display("FAIL basic_filt_in c=%0d got=%h exp=%h", c, filt_in, {24'hA5A5A5, 8'(c - 2)});
        end
      end
      if (c >= 6 && c <= 9) begin
        n_cmp++;
        if (ram_addr !== 8'(c - 6) || ram_data !== 32'h5A00_0000 + cyc) begin
          n_bad++;
          $display("FAIL basic_write c=%0d got=%0d/%h exp=%0d/%h", c, ram_addr, ram_data,
                   c - 6, 32'h5A00_0000 + cyc);
        end
      end else begin
        n_cmp++;
        if (ram_data !== 32'h0) begin
          n_bad++;
          $display("FAIL basic_ram_data_idle c=%0d got=%h exp=0", c, ram_data);
        end
      end
      $display("basic c=%0d addr=%0d en=%b wren=%b waddr=%0d busy=%b done=%b",
               c, rom_addr, filt_en, ram_wren, ram_addr, busy, done);
      tick();
    end
  endtask

  task automatic test_single;
    int en_n = 0, wr_n = 0, wr_c = -1, done_c = -1;
    logic [7:0] wr_a = 8'hFF;
    launch(8'd0);
    for (int c = 1; c <= 12; c++) begin
      if (filt_en) en_n++;
      if (ram_wren) begin wr_n++; wr_a = ram_addr; wr_c = c; end
      if (done) done_c = c;
      tick();
    end
    n_cmp++;
    if (en_n != 1 || wr_n != 1) begin
      n_bad++;
      $display("FAIL single_counts got en=%0d wr=%0d exp en=1 wr=1", en_n, wr_n);
    end
    n_cmp++;
    if (wr_a !== 8'd0 || wr_c != 6) begin
      n_bad++;
      $display("FAIL single_write got addr=%0d cyc=%0d exp addr=0 cyc=6", wr_a, wr_c);
    end
    n_cmp++;
    if (done_c != 7) begin
      n_bad++;
      $display("FAIL single_done got=%0d exp=7", done_c);
    end
    $display("single: en=%0d wr=%0d waddr=%0d done_cycle=%0d", en_n, wr_n, wr_a, done_c);
  endtask

  task automatic test_full;
    int k = 0, done_n = 0;
    logic [7:0] last_a = 8'h00;
    launch(8'd255);
    for (int c = 1; c <= 300; c++) begin
      if (ram_wren) begin
        n_cmp++;
        if (ram_addr !== 8'(k)) begin
          n_bad++;
          $display("FAIL full_addr write=%0d got=%0d exp=%0d", k, ram_addr, k);
        end
        last_a = ram_addr;
        k++;
      end
      if (done) done_n++;
      tick();
    end
    n_cmp++;
    if (k != 256 || last_a !== 8'd255) begin
      n_bad++;
      $display("FAIL full_count got writes=%0d last=%0d exp writes=256 last=255", k, last_a);
    end
    n_cmp++;
    if (done_n != 1) begin
      n_bad++;
      $display("FAIL full_done got=%0d exp=1", done_n);
    end
    $display("full: writes=%0d last=%0d done=%0d", k, last_a, done_n);
  endtask

  task automatic test_start_ignored;
    int wr_n = 0, done_n = 0;
    bit seen_done = 0, busy_after = 0;
    launch(8'd7);
    for (int c = 1; c <= 30; c++) begin
      if (ram_wren) wr_n++;
      if (seen_done && (busy || filt_en)) busy_after = 1;
      if (done) begin done_n++; seen_done = 1; end
      if (c == 3) begin start = 1'b1; num_samples = 8'd2; end
      else start = done;
      tick();
    end
    start = 1'b0;
    n_cmp++;
    if (wr_n != 8 || done_n != 1) begin
      n_bad++;
      $display("FAIL ignore_counts got wr=%0d done=%0d exp wr=8 done=1", wr_n, done_n);
    end
    n_cmp++;
    if (busy_after) begin
      n_bad++;
      $display("FAIL ignore_idle got=restarted exp=idle");
    end
    $display("ignore: writes=%0d done=%0d restarted=%0d", wr_n, done_n, busy_after);
  endtask

  task automatic test_reset_mid;
    bit found = 0;
    int wr_n = 0, first_c = -1;
    logic [127:0] obs;
    launch(8'd63);
    for (int c = 0; c < 20 && !found; c++) begin
      if (rom_addr == 8'd10) found = 1;
      else tick();
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL midreset_wait got=timeout exp=rom_addr 10");
    end
    rst = 1'b0;
    #1;
    obs = {rom_addr, ram_addr, ram_data, filt_in, filt_en, ram_wren, busy, done, trig,
           rom_addr2, ram_addr2, ram_wren2, filt_en2, busy2, done2, trig2, 16'h0};
    n_cmp++;
    if (obs !== 128'h0) begin
      n_bad++;
      $display("FAIL midreset_outputs got=%h exp=0", obs);
    end
    tick(); tick();
    rst = 1'b1;
    launch(8'd3);
    n_cmp++;
    if (busy !== 1'b1 || rom_addr !== 8'd0 || trig !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_restart got busy=%b addr=%0d trig=%b exp 1/0/1", busy, rom_addr, trig);
    end
    for (int c = 1; c <= 12; c++) begin
      if (ram_wren) begin
        if (first_c < 0) first_c = c;
        n_cmp++;
        if (ram_addr !== 8'(wr_n)) begin
          n_bad++;
          $display("FAIL midreset_addr c=%0d got=%0d exp=%0d", c, ram_addr, wr_n);
        end
        wr_n++;
      end
      tick();
    end
    n_cmp++;
    if (wr_n != 4 || first_c != 6) begin
      n_bad++;
      $display("FAIL midreset_writes got wr=%0d first=%0d exp wr=4 first=6", wr_n, first_c);
    end
    $display("midreset: restart writes=%0d first_cycle=%0d", wr_n, first_c);
  endtask

  task automatic test_latency;
    logic [3:0] o, e;
    launch(8'd4);
    for (int c = 1; c <= 17; c++) begin
      e = {c <= 14, c == 15, c >= 3 && c <= 7, c >= 10 && c <= 14};
      o = {busy2, done2, filt_en2, ram_wren2};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL lat_ctrl c=%0d got=%b exp=%b (busy,done,en,wren)", c, o, e);
      end
      if (c <= 5) begin
        n_cmp++;
        if (rom_addr2 !== 8'(c - 1)) begin
          n_bad++;
          $display("FAIL lat_rom_addr c=%0d got=%0d exp=%0d", c, rom_addr2, c - 1);
        end
      end
      if (c >= 10 && c <= 14) begin
        n_cmp++;
        if (ram_addr2 !== 8'(c - 10)) begin
          n_bad++;
          $display("FAIL lat_ram_addr c=%0d got=%0d exp=%0d", c, ram_addr2, c - 10);
        end
      end
      $display("latency c=%0d addr=%0d en=%b wren=%b waddr=%0d busy=%b done=%b",
               c, rom_addr2, filt_en2, ram_wren2, ram_addr2, busy2, done2);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    repeat (20) tick();
    test_single();
    repeat (20) tick();
    test_full();
    repeat (20) tick();
    test_start_ignored();
    repeat (20) tick();
    test_reset_mid();
    repeat (20) tick();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
